// File: rtl/pulse_generator_multi.sv
// Multi-channel programmable pulse/PWM generator.
// Each channel runs an IDLE/RUN state machine with its own N-bit counter,
// period (ticks), high-time (width), mode (periodic / one-shot) and enable.
// Optional feature macro: PULSE_GENERATOR_MULTI_RETRIGGER_EN
//   defined     -> a start during a one-shot RUN restarts the shot at count 0
//   not defined -> start during RUN is ignored
module pulse_generator_multi #(
    parameter int N = 8,
    parameter int C = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [C-1:0]   ch_ena,
    input  logic [C-1:0]   mode,
    input  logic [C-1:0]   start,
    input  logic [C*N-1:0] ticks,
    input  logic [C*N-1:0] width,
    output logic [C-1:0]   out,
    output logic [C-1:0]   wrap,
    output logic [C-1:0]   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state    [C];
    state_t       state_nx [C];
    logic [N-1:0] count    [C];
    logic [N-1:0] count_nx [C];
    logic [N-1:0] tk       [C];
    logic [N-1:0] wd       [C];
    logic [N-1:0] last     [C];
    logic [C-1:0] at_end;

    // Per-channel field unpacking, period-end compare and output decode.
    // last wraps to all-ones when ticks is 0; that case is forced to IDLE.
    for (genvar g = 0; g < C; g++) begin : g_ch
        assign tk[g]     = ticks[g*N +: N];
        assign wd[g]     = width[g*N +: N];
        assign last[g]   = tk[g] - 1'b1;
        assign at_end[g] = (count[g] >= last[g]);
        assign busy[g]   = (state[g] == RUN);
        assign out[g]    = (state[g] == RUN) & ena & (count[g] < wd[g]);
        assign wrap[g]   = (state[g] == RUN) & ena & at_end[g];
    end

    // Next-state and next-count for every channel.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            state_nx[i] = state[i];
            count_nx[i] = count[i];
            if (state[i] == IDLE) begin
                if (ena && ch_ena[i] && (tk[i] != '0) && (!mode[i] || start[i])) begin
                    state_nx[i] = RUN;
                    count_nx[i] = '0;
                end
            end else begin
                // Losing the channel enable or the period drops to IDLE even while frozen.
                if (!ch_ena[i] || (tk[i] == '0)) begin
                    state_nx[i] = IDLE;
                    count_nx[i] = '0;
                end else if (ena) begin
`ifdef PULSE_GENERATOR_MULTI_RETRIGGER_EN
                    if (mode[i] && start[i]) begin
                        count_nx[i] = '0;
                    end else
`endif
                    if (at_end[i]) begin
                        count_nx[i] = '0;
                        if (mode[i]) begin
                            state_nx[i] = IDLE;
                        end
                    end else begin
                        count_nx[i] = count[i] + 1'b1;
                    end
                end
            end
        end
    end

    // State and counter registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < C; i++) begin
                state[i] <= IDLE;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C; i++) begin
                state[i] <= state_nx[i];
                count[i] <= count_nx[i];
            end
        end
    end

endmodule
